mdu_ctrl: RTL and testbench

Multi-cycle multiply/divide sequencer for the MIPS pipeline's EX stage. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX, models fixed multi-cycle latency with a busy counter, and commits results to architectural HI/LO. It drives the stall that holds later HI/LO-dependent instructions in decode until results are valid.

---
 rtl/mdu_pkg.sv | 28 ++
 rtl/mdu_arith.sv | 65 ++++++
 rtl/mdu_ctrl.sv | 103 ++++++++++
 tb/tb_mdu_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states,
// default latencies and the busy-counter width.
package mdu_pkg;

    localparam int CNT_W           = 4;
    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5
    } mdu_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mdu_state_e;

    // True for the four ops that occupy the unit for several cycles.
    function automatic logic is_arith_op(input logic [2:0] op);
        return (op <= 3'd3);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath. Produces {hi, lo} for the
// arithmetic ops, including the MIPS-style divide-by-zero and signed
// overflow results, so the controller only has to latch the value.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] result
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        div_zero;
    logic        div_ovf;
    logic [31:0] b_safe_s;
    logic [31:0] b_safe_u;
    logic [31:0] quo_s;
    logic [31:0] rem_s;
    logic [31:0] quo_u;
    logic [31:0] rem_u;

    assign prod_s   = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u   = {32'd0, a} * {32'd0, b};
    assign div_zero = (b == 32'd0);
    assign div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

    // The special cases are answered directly below; the divider sees a
    // harmless divisor so it never divides by zero or overflows.
    assign b_safe_s = (div_zero || div_ovf) ? 32'd1 : b;
    assign b_safe_u = div_zero ? 32'd1 : b;

    assign quo_s = $signed(a) / $signed(b_safe_s);
    assign rem_s = $signed(a) % $signed(b_safe_s);
    assign quo_u = a / b_safe_u;
    assign rem_u = a % b_safe_u;

    // Select the {hi, lo} pair for the requested op.
    always_comb begin
        result = 64'd0;
        case (op)
            MDU_MULT:  result = prod_s;
            MDU_MULTU: result = prod_u;
            MDU_DIV: begin
                if (div_zero) begin
                    result = {a, 32'hFFFF_FFFF};
                end else if (div_ovf) begin
                    result = {32'd0, 32'h8000_0000};
                end else begin
                    result = {rem_s, quo_s};
                end
            end
            MDU_DIVU: begin
                if (div_zero) begin
                    result = {a, 32'hFFFF_FFFF};
                end else begin
                    result = {rem_u, quo_u};
                end
            end
            default: result = 64'd0;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer for the EX stage. Latches the result of an
// arithmetic op at issue, holds busy for a fixed latency, then commits to
// the architectural HI/LO registers. MTHI/MTLO write HI/LO directly.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        md_use,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    mdu_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [63:0]      pend_q;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;
    logic             busy_q;
    logic [63:0]      arith_res;

    mdu_arith u_arith (
        .op     (op),
        .a      (a),
        .b      (b),
        .result (arith_res)
    );

    // Sequencer: issue in IDLE, count down in BUSY, commit on the last cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= CNT_ZERO;
            pend_q  <= 64'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        case (op)
                            MDU_MULT, MDU_MULTU: begin
                                pend_q  <= arith_res;
                                cnt_q   <= MULT_LOAD;
                                state_q <= BUSY;
                                busy_q  <= 1'b1;
                            end
                            MDU_DIV, MDU_DIVU: begin
                                pend_q  <= arith_res;
                                cnt_q   <= DIV_LOAD;
                                state_q <= BUSY;
                                busy_q  <= 1'b1;
                            end
                            MDU_MTHI: hi_q <= a;
                            MDU_MTLO: lo_q <= a;
                            default: begin
                                // Reserved encodings leave all state untouched.
                            end
                        endcase
                    end
                end
                BUSY: begin
                    // Any start arriving here is a protocol violation and is dropped.
                    if (cnt_q == CNT_ONE) begin
                        hi_q    <= pend_q[63:32];
                        lo_q    <= pend_q[31:0];
                        cnt_q   <= CNT_ZERO;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Stall must react in the issue cycle itself, so it stays combinational.
    assign stall = md_use & (busy_q | (start & is_arith_op(op)));
    assign busy  = busy_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed and randomized bench for mdu_ctrl with a behavioural HI/LO model.
module tb_mdu_ctrl;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        md_use;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    always #5 clk = ~clk;

    mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .md_use (md_use),
        .busy   (busy),
        .stall  (stall),
        .hi     (hi),
        .lo     (lo)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference {hi, lo} from the architectural rules, using sign/magnitude division.
    function automatic logic [63:0] ref_calc(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
        longint sa, sb, ma, mb, q, r, p;
        longint unsigned ua, ub, pu;
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        ua = {32'd0, av};
        ub = {32'd0, bv};
        case (o)
            3'd0: begin p = sa * sb; return p; end
            3'd1: begin pu = ua * ub; return pu; end
            3'd2: begin
                if (bv == 32'd0) return {av, 32'hFFFF_FFFF};
                ma = (sa < 64'sd0) ? -sa : sa;
                mb = (sb < 64'sd0) ? -sb : sb;
                q  = ma / mb;
                r  = ma % mb;
                if ((sa < 64'sd0) != (sb < 64'sd0)) q = -q;
                if (sa < 64'sd0) r = -r;
                return {r[31:0], q[31:0]};
            end
            3'd3: begin
                if (bv == 32'd0) return {av, 32'hFFFF_FFFF};
                return {32'(ua % ub), 32'(ua / ub)};
            end
            default: return {exp_hi, exp_lo};
        endcase
    endfunction

    // Issue an arithmetic op at the current (post-negedge) time and follow it to commit.
    task automatic do_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                         input logic md, input logic inject);
        logic [63:0] r;
        int n;
        r = ref_calc(o, av, bv);
        n = (o <= 3'd1) ? MC : DC;
        start = 1'b1; op = o; a = av; b = bv; md_use = md;
        #1;
        chk("stall_issue", stall, md);
        chk("busy_issue", busy, 64'd0);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom;
        for (int k = 0; k < n; k++) begin
            if (inject && k == 1) begin
                start = 1'b1;
                op = 3'($urandom_range(0, 5));
                a = $urandom;
                b = $urandom;
            end else begin
                start = 1'b0;
            end
            #1;
            chk("busy_run", busy, 64'd1);
            chk("stall_run", stall, md);
            chk("hi_hold", hi, exp_hi);
            chk("lo_hold", lo, exp_lo);
            @(negedge clk);
        end
        start = 1'b0;
        exp_hi = r[63:32];
        exp_lo = r[31:0];
        #1;
        chk("busy_done", busy, 64'd0);
        chk("stall_done", stall, 64'd0);
        chk("hi_commit", hi, exp_hi);
        chk("lo_commit", lo, exp_lo);
    endtask

    // MTHI/MTLO or reserved op: single-edge effect, never stalls or busies.
    task automatic do_mt(input logic [2:0] o, input logic [31:0] av, input logic md);
        start = 1'b1; op = o; a = av; b = $urandom; md_use = md;
        #1;
        chk("stall_mt", stall, 64'd0);
        chk("busy_mt_pre", busy, 64'd0);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        if (o == 3'd4) exp_hi = av;
        else if (o == 3'd5) exp_lo = av;
        #1;
        chk("busy_mt", busy, 64'd0);
        chk("hi_mt", hi, exp_hi);
        chk("lo_mt", lo, exp_lo);
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        reset = 1'b1; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0; md_use = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", busy, 64'd0);
        chk("rst_stall", stall, 64'd0);
        chk("rst_hi", hi, 64'd0);
        chk("rst_lo", lo, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        do_op(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b1, 1'b0);
        chk("mult_const", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFA});
        do_op(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b1, 1'b0);
        chk("multu_const", {hi, lo}, {32'h0000_0002, 32'hFFFF_FFFA});
        do_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
        chk("div_const", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        do_op(3'd3, 32'd7, 32'd2, 1'b0, 1'b0);
        chk("divu_const", {hi, lo}, {32'd1, 32'd3});
        do_op(3'd2, 32'h0000_1234, 32'd0, 1'b1, 1'b0);
        chk("div0_const", {hi, lo}, {32'h0000_1234, 32'hFFFF_FFFF});
        do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
        chk("divovf_const", {hi, lo}, {32'd0, 32'h8000_0000});
        do_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
        do_op(3'd0, 32'h0001_0003, 32'hFFF0_0007, 1'b1, 1'b1);

        do_mt(3'd4, 32'hDEAD_BEEF, 1'b1);
        chk("mthi_const", hi, 32'hDEAD_BEEF);
        do_op(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0);
        do_op(3'd2, 32'h7FFF_FFFF, 32'hFFFF_FFFD, 1'b1, 1'b0);
        do_mt(3'd5, 32'hCAFE_F00D, 1'b0);
        do_mt(3'd6, 32'h5555_AAAA, 1'b1);
        do_mt(3'd7, 32'hAAAA_5555, 1'b1);

        for (int i = 0; i < 24; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 9));
                default: ;
            endcase
            if (ro <= 3'd3) do_op(ro, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else do_mt(ro, ra, 1'($urandom_range(0, 1)));
        end

        do_mt(3'd4, 32'h0BAD_F00D, 1'b1);
        do_mt(3'd5, 32'h1357_9BDF, 1'b1);
        start = 1'b1; op = 3'd2; a = 32'd1000; b = 32'd7; md_use = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("pre_rst_busy", busy, 64'd1);
        reset = 1'b1;
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        #1;
        chk("midrst_busy", busy, 64'd0);
        chk("midrst_hi", hi, 64'd0);
        chk("midrst_lo", lo, 64'd0);
        chk("midrst_stall", stall, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < DC + 3; k++) begin
            @(negedge clk);
            #1;
            chk("post_rst_busy", busy, 64'd0);
            chk("post_rst_hilo", {hi, lo}, {exp_hi, exp_lo});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
